fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with a registered instruction queue feeding decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        cpu_halt,
    input  logic        pipe_flush,
    input  logic [31:0] flush_pc,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ack,
    input  logic [31:0] ic_rd_data,
    output logic        f2d_valid,
    input  logic        f2d_rdy,
    output logic [31:0] f2d_pc,
    output logic [31:0] f2d_ins
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        r_state, w_state_nx;
    logic [31:0]   r_pc, w_pc_nx, r_addr, w_addr_nx;
    logic [31:0]   r_qpc [QDEPTH];
    logic [31:0]   r_qins [QDEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count, w_count_nx;
    logic          w_push, w_pop;
    logic [31:0]   w_flush_pc;

    assign ic_req     = r_state != IDLE;
    assign ic_addr    = r_addr;
    assign f2d_valid  = r_count != '0;
    assign f2d_pc     = r_qpc[r_head];
    assign f2d_ins    = r_qins[r_head];
    assign w_flush_pc = {flush_pc[31:2], 2'b00};

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = pipe_flush ? w_flush_pc : r_pc;
        w_addr_nx  = r_addr;
        w_push     = r_state == REQ && ic_ack && !pipe_flush;
        w_pop      = f2d_valid && f2d_rdy && !pipe_flush;
        w_count_nx = pipe_flush ? '0 : r_count + CW'(w_push) - CW'(w_pop);
        case (r_state)
            IDLE: if (!cpu_halt && !pipe_flush && r_count < FULL) begin
                w_state_nx = REQ;
                w_addr_nx  = r_pc;
            end
            REQ: if (pipe_flush) begin
                w_state_nx = ic_ack ? IDLE : DROP;
            end else if (ic_ack) begin
                w_pc_nx = r_addr + 32'd4;
                // chain the next fetch only if the queue will still have room after this push
                if (!cpu_halt && w_count_nx < FULL) w_addr_nx = r_addr + 32'd4;
                else w_state_nx = IDLE;
            end
            DROP: w_state_nx = ic_ack ? IDLE : DROP;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_qpc[i]  <= '0;
                r_qins[i] <= '0;
            end
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_addr  <= w_addr_nx;
            r_count <= w_count_nx;
            if (pipe_flush) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_qpc[r_tail]  <= r_addr;
                    r_qins[r_tail] <= ic_rd_data;
                    r_tail         <= r_tail + 1'b1;
                end
                if (w_pop) r_head <= r_head + 1'b1;
            end
        end
    end
endmodule
